pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage ARM core (IF, ID, EXE, MEM, WB).
- Holds its own shadow copy of the destination tags of instructions in EXE and MEM.
- Detects RAW hazards against the instruction currently in ID, and runs the multi-cycle SRAM access handshake for the MEM stage.
- Drives freeze/flush controls for the PC, the IF/ID register and the ID/EXE register, plus a global freeze while memory is busy.

---
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID-stage operand info, branch/memory
// status in, stage freeze/flush controls and diagnostics out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_two_src;
    logic             id_wb_en;
    logic             id_mem_r_en;
    logic [3:0]       id_dest;
    logic             exe_branch_taken;
    logic             mem_req;
    logic             sram_ready;

    logic             sram_start;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             freeze_all;
    logic             hazard;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side
    modport master (
        output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en, id_dest,
               exe_branch_taken, mem_req, sram_ready,
        input  sram_start, freeze_pc, freeze_if_id, flush_if_id, flush_id_ex,
               freeze_all, hazard, mem_err, stall_cnt
    );

    // Controller side
    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_mem_r_en, id_dest,
               exe_branch_taken, mem_req, sram_ready,
        output sram_start, freeze_pc, freeze_if_id, flush_if_id, flush_id_ex,
               freeze_all, hazard, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage core: shadow EXE/MEM destination tags,
// RAW hazard detection for ID, SRAM access handshake with timeout, and the
// freeze/flush controls derived from them.
module pipe_hazard_ctrl #(
    parameter int FORWARD_EN  = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic       v;
        logic       wb;
        logic       ld;
        logic [3:0] dest;
    } tag_t;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    tag_t             r_exe_tag;
    tag_t             r_mem_tag;
    state_t           r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_match_exe;
    logic w_match_mem;
    logic w_hazard;
    logic w_mem_stall;
    logic w_freeze_pc;
    logic w_issue;

    function automatic logic f_match(input tag_t t, input logic [3:0] s1,
                                     input logic [3:0] s2, input logic two);
        return t.v & t.wb & ((s1 == t.dest) | (two & (s2 == t.dest)));
    endfunction

    assign w_match_exe = f_match(r_exe_tag, bus.id_src1, bus.id_src2, bus.id_two_src);
    assign w_match_mem = f_match(r_mem_tag, bus.id_src1, bus.id_src2, bus.id_two_src);

    // With forwarding only a load in EXE cannot be bypassed in time
    assign w_hazard    = bus.id_valid & ((FORWARD_EN != 0) ? (w_match_exe & r_exe_tag.ld)
                                                           : (w_match_exe | w_match_mem));
    // The pipeline advances on the ready cycle itself
    assign w_mem_stall = bus.mem_req & ~((r_state == S_BUSY) & bus.sram_ready);
    assign w_freeze_pc = w_mem_stall | (w_hazard & ~bus.exe_branch_taken);
    assign w_issue     = bus.id_valid & ~w_hazard & ~bus.exe_branch_taken;

    // Everything is forced quiet while reset is held, even if inputs are active
    assign bus.freeze_all   = ~rst & w_mem_stall;
    assign bus.freeze_pc    = ~rst & w_freeze_pc;
    assign bus.freeze_if_id = ~rst & w_freeze_pc;
    assign bus.flush_if_id  = ~rst & bus.exe_branch_taken & ~w_mem_stall;
    assign bus.flush_id_ex  = ~rst & (w_hazard | bus.exe_branch_taken) & ~w_mem_stall;
    assign bus.hazard       = ~rst & w_hazard;
    assign bus.sram_start   = ~rst & (r_state == S_IDLE) & bus.mem_req;
    assign bus.mem_err      = r_mem_err;
    assign bus.stall_cnt    = r_stall_cnt;

    // Shadow tags move with the pipeline and hold while memory freezes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exe_tag <= '0;
            r_mem_tag <= '0;
        end else if (!w_mem_stall) begin
            r_mem_tag <= r_exe_tag;
            r_exe_tag <= w_issue ? {1'b1, bus.id_wb_en, bus.id_mem_r_en, bus.id_dest} : '0;
        end
    end

    // SRAM handshake: start in IDLE, wait for ready or give up after MEM_TIMEOUT cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.mem_req) begin
                        r_state    <= S_BUSY;
                        r_wait_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    if (bus.sram_ready) begin
                        r_state <= S_IDLE;
                    end else if (r_wait_cnt == LP_WAIT_LAST) begin
                        r_mem_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Saturating count of PC-frozen cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_freeze_pc && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (forwarding/timeout 8 and
// no-forwarding/timeout 5) share one stimulus stream; a reference model
// queues expected outputs per cycle and a negedge monitor checks them.
module tb_pipe_hazard_ctrl;
    localparam int CW = 8;
    localparam int N  = 2;

    typedef struct packed {
        logic       v;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic       wb;
        logic       ld;
        logic [3:0] dst;
        logic       br;
        logic       mreq;
        logic       rdy;
    } stim_t;

    typedef struct packed {
        logic          start;
        logic          fpc;
        logic          fifid;
        logic          flif;
        logic          flex;
        logic          fall;
        logic          haz;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    typedef struct packed {
        bit       v;
        bit       wb;
        bit       ld;
        bit [3:0] dest;
    } inst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) ifa ();
    pipe_hazard_ctrl_if #(.CNT_W(CW)) ifb ();

    pipe_hazard_ctrl #(.FORWARD_EN(1), .MEM_TIMEOUT(8), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa));
    pipe_hazard_ctrl #(.FORWARD_EN(0), .MEM_TIMEOUT(5), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb));

    int n_chk  = 0;
    int n_fail = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state: instructions sitting in EXE and MEM, memory access progress
    inst_t m_exe [N];
    inst_t m_mem [N];
    bit    m_busy[N];
    int    m_age [N];
    bit    m_err [N];
    int    m_cnt [N];

    function automatic bit hits(input inst_t t, input stim_t s);
        return t.v && t.wb && ((s.s1 == t.dest) || (s.two && (s.s2 == t.dest)));
    endfunction

    task automatic model(input int d, input stim_t s, input bit r, output exp_t e);
        bit hz, stall, fpc, fwd;
        int to;
        fwd = (d == 0);
        to  = (d == 0) ? 8 : 5;
        e   = '0;
        if (r) begin
            m_exe[d] = '0; m_mem[d] = '0; m_busy[d] = 0; m_age[d] = 0;
            m_err[d] = 0;  m_cnt[d] = 0;
            return;
        end
        hz    = s.v && (fwd ? (hits(m_exe[d], s) && m_exe[d].ld)
                            : (hits(m_exe[d], s) || hits(m_mem[d], s)));
        stall = s.mreq && !(m_busy[d] && s.rdy);
        fpc   = stall || (hz && !s.br);
        e.start = s.mreq && !m_busy[d];
        e.fall  = stall;
        e.fpc   = fpc;
        e.fifid = fpc;
        e.flif  = s.br && !stall;
        e.flex  = (hz || s.br) && !stall;
        e.haz   = hz;
        e.err   = m_err[d];
        e.cnt   = CW'(m_cnt[d]);
        // state after the clock edge ending this cycle
        if (fpc && m_cnt[d] < (1 << CW) - 1) m_cnt[d]++;
        if (!stall) begin
            m_mem[d] = m_exe[d];
            if (s.v && !hz && !s.br) m_exe[d] = {1'b1, s.wb, s.ld, s.dst};
            else                     m_exe[d] = '0;
        end
        if (!m_busy[d]) begin
            if (s.mreq) begin
                m_busy[d] = 1;
                m_age[d]  = 0;
            end
        end else if (s.rdy) begin
            m_busy[d] = 0;
        end else begin
            m_age[d]++;
            if (m_age[d] == to) begin
                m_err[d]  = 1;
                m_busy[d] = 0;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        ifa.id_valid = s.v;   ifa.id_src1 = s.s1;  ifa.id_src2 = s.s2;
        ifa.id_two_src = s.two; ifa.id_wb_en = s.wb; ifa.id_mem_r_en = s.ld;
        ifa.id_dest = s.dst;  ifa.exe_branch_taken = s.br;
        ifa.mem_req = s.mreq; ifa.sram_ready = s.rdy;
        ifb.id_valid = s.v;   ifb.id_src1 = s.s1;  ifb.id_src2 = s.s2;
        ifb.id_two_src = s.two; ifb.id_wb_en = s.wb; ifb.id_mem_r_en = s.ld;
        ifb.id_dest = s.dst;  ifb.exe_branch_taken = s.br;
        ifb.mem_req = s.mreq; ifb.sram_ready = s.rdy;
    endtask

    // One cycle: inputs (and rst) change off-edge, expectation queued before negedge
    task automatic apply(input stim_t s, input bit r);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        drive(s);
        #2;
        model(0, s, r, e); q_a.push_back(e);
        model(1, s, r, e); q_b.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input string l, input exp_t a, input exp_t e);
        chk({l, ".sram_start"},   a.start, e.start);
        chk({l, ".freeze_pc"},    a.fpc,   e.fpc);
        chk({l, ".freeze_if_id"}, a.fifid, e.fifid);
        chk({l, ".flush_if_id"},  a.flif,  e.flif);
        chk({l, ".flush_id_ex"},  a.flex,  e.flex);
        chk({l, ".freeze_all"},   a.fall,  e.fall);
        chk({l, ".hazard"},       a.haz,   e.haz);
        chk({l, ".mem_err"},      a.err,   e.err);
        chk({l, ".stall_cnt"},    int'(a.cnt), int'(e.cnt));
    endtask

    // Monitor: compares whatever the DUTs present against the queued expectations
    always @(negedge clk) begin
        exp_t a, e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            a = {ifa.sram_start, ifa.freeze_pc, ifa.freeze_if_id, ifa.flush_if_id,
                 ifa.flush_id_ex, ifa.freeze_all, ifa.hazard, ifa.mem_err, ifa.stall_cnt};
            cmp("fwd1", a, e);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            a = {ifb.sram_start, ifb.freeze_pc, ifb.freeze_if_id, ifb.flush_if_id,
                 ifb.flush_id_ex, ifb.freeze_all, ifb.hazard, ifb.mem_err, ifb.stall_cnt};
            cmp("fwd0", a, e);
        end
    end

    initial begin
        stim_t s;
        s = '0;
        drive(s);
        repeat (3) apply(s, 1'b1);

        // load-use: LDR R2, then a reader of R2 held in ID
        s = '0; s.v = 1; s.wb = 1; s.ld = 1; s.dst = 2; s.s1 = 5; apply(s, 0);
        s = '0; s.v = 1; s.s1 = 2; s.wb = 1; s.dst = 7; repeat (2) apply(s, 0);
        s = '0; repeat (3) apply(s, 0);

        // ALU dependency through src2 with two_src set
        s = '0; s.v = 1; s.wb = 1; s.dst = 3; apply(s, 0);
        s = '0; s.v = 1; s.s1 = 9; s.s2 = 3; s.two = 1; s.wb = 1; s.dst = 4; repeat (3) apply(s, 0);
        // src2 match ignored when two_src is clear
        s = '0; s.v = 1; s.wb = 1; s.dst = 6; apply(s, 0);
        s = '0; s.v = 1; s.s1 = 9; s.s2 = 6; repeat (2) apply(s, 0);
        s = '0; repeat (2) apply(s, 0);

        // memory access with a load in EXE and its reader in ID; ready 5 cycles after start
        s = '0; s.v = 1; s.wb = 1; s.ld = 1; s.dst = 1; apply(s, 0);
        s = '0; s.v = 1; s.s1 = 1; s.mreq = 1; repeat (5) apply(s, 0);
        s.rdy = 1; apply(s, 0);
        s = '0; s.v = 1; s.s1 = 1; apply(s, 0);
        s = '0; s.rdy = 1; apply(s, 0);   // stray ready in IDLE
        s = '0; repeat (2) apply(s, 0);

        // branch taken while frozen
        s = '0; s.mreq = 1; s.br = 1; repeat (3) apply(s, 0);
        s.rdy = 1; apply(s, 0);
        s = '0; repeat (2) apply(s, 0);

        // timeout with request held, then released
        s = '0; s.mreq = 1; repeat (14) apply(s, 0);
        s = '0; repeat (10) apply(s, 0);

        // asynchronous reset in the middle of an access
        s = '0; s.mreq = 1; s.br = 1; repeat (3) apply(s, 0);
        apply(s, 1);
        s = '0; apply(s, 1);
        repeat (3) apply(s, 0);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            s.v    = ($urandom_range(0, 3) != 0);
            s.s1   = 4'($urandom_range(0, 3));
            s.s2   = 4'($urandom_range(0, 3));
            s.two  = 1'($urandom_range(0, 1));
            s.wb   = ($urandom_range(0, 4) != 0);
            s.ld   = ($urandom_range(0, 2) == 0);
            s.dst  = 4'($urandom_range(0, 3));
            s.br   = ($urandom_range(0, 7) == 0);
            s.mreq = ($urandom_range(0, 3) == 0);
            s.rdy  = ($urandom_range(0, 2) == 0);
            apply(s, ($urandom_range(0, 149) == 0));
        end

        // long freeze to drive stall_cnt into saturation
        s = '0; s.mreq = 1; repeat (300) apply(s, 0);
        s = '0; repeat (4) apply(s, 0);

        repeat (3) @(posedge clk);
        chk("queue_drained", q_a.size() + q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
